// File: rtl/magcomp_pkg.sv
// Shared constants for the serial magnitude comparator: FSM encoding and slice result codes.
package magcomp_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 2-bit slice compare outcome
    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_GT = 2'b01;
    localparam logic [1:0] RES_LT = 2'b10;

endpackage

// File: rtl/magc2bit.sv
// Combinational 2-bit magnitude comparator producing a result code.
module magc2bit
    import magcomp_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] code
);

    logic gt;
    logic lt;

    // MSB decides unless both MSBs match, then LSB decides
    assign gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
    assign lt = (~a[1] & b[1]) | (~(a[1] ^ b[1]) & ~a[0] & b[0]);

    assign code = gt ? RES_GT : (lt ? RES_LT : RES_EQ);

endmodule

// File: rtl/serial_magcomp_ctrl.sv
// Serial magnitude comparator: walks 2-bit slices MSB first, stops on the first difference.
module serial_magcomp_ctrl
    import magcomp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AGB,
    output logic             AEB,
    output logic             ALB
);

    localparam int unsigned SLICES   = WIDTH / 2;
    localparam int unsigned IDX_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_n;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   a_n;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   b_n;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_n;
    logic               busy_n;
    logic               done_n;
    logic               agb_n;
    logic               aeb_n;
    logic               alb_n;

    logic [1:0] a_slice;
    logic [1:0] b_slice;
    logic [1:0] code;

    // Select the current slice [2*idx+1 : 2*idx] of the latched operands
    assign a_slice = 2'(a_q >> {idx, 1'b0});
    assign b_slice = 2'(b_q >> {idx, 1'b0});

    magc2bit u_slice_cmp (
        .a    (a_slice),
        .b    (b_slice),
        .code (code)
    );

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        idx_n   = idx;
        agb_n   = AGB;
        aeb_n   = AEB;
        alb_n   = ALB;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_n     = A;
                    b_n     = B;
                    idx_n   = IDX_LAST;
                    state_n = ST_CMP;
                end
            end
            ST_CMP: begin
                if (code != RES_EQ) begin
                    agb_n   = (code == RES_GT);
                    alb_n   = (code == RES_LT);
                    aeb_n   = 1'b0;
                    state_n = ST_DONE;
                end else if (idx == '0) begin
                    agb_n   = 1'b0;
                    alb_n   = 1'b0;
                    aeb_n   = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    idx_n = idx - IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of what the next state implies
        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            AGB   <= 1'b0;
            AEB   <= 1'b0;
            ALB   <= 1'b0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            idx   <= idx_n;
            busy  <= busy_n;
            done  <= done_n;
            AGB   <= agb_n;
            AEB   <= aeb_n;
            ALB   <= alb_n;
        end
    end

endmodule

// File: tb/tb_serial_magcomp_ctrl.sv
// Self-checking bench for serial_magcomp_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_magcomp_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         AGB;
    logic         AEB;
    logic         ALB;

    int n_assert;
    int n_fail;

    // Last completed result seen by the model (all zero after reset)
    logic exp_agb;
    logic exp_aeb;
    logic exp_alb;

    serial_magcomp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .AGB   (AGB),
        .AEB   (AEB),
        .ALB   (ALB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slices the comparator must look at: up to and including the slice holding the top differing bit
    function automatic int unsigned slices_needed(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] diff;
        diff = a ^ b;
        if (diff == '0) return W / 2;
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) return (W / 2) - (i / 2);
        end
        return W / 2;
    endfunction

    // One comparison; hold_start keeps start high afterwards, scramble wiggles A/B while busy
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold_start, input bit scramble);
        int unsigned k;
        int          edges;
        bit          got;
        k = slices_needed(a, b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_accept_busy"}, 32'(busy), 32'd1);
        check({tag, "_accept_done"}, 32'(done), 32'd0);
        start = hold_start;
        if (scramble) begin
            A = W'($urandom);
            B = W'($urandom);
        end
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                got = 1'b1;
            end else begin
                check({tag, "_wait_busy"}, 32'(busy), 32'd1);
                check({tag, "_hold_res"}, {29'd0, AGB, AEB, ALB}, {29'd0, exp_agb, exp_aeb, exp_alb});
            end
            if (scramble) begin
                A = W'($urandom);
                B = W'($urandom);
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(edges + 1), 32'(k + 1));
        exp_agb = (a > b);
        exp_aeb = (a == b);
        exp_alb = (a < b);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tag, "_result"}, {29'd0, AGB, AEB, ALB}, {29'd0, exp_agb, exp_aeb, exp_alb});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_res"}, {29'd0, AGB, AEB, ALB}, {29'd0, exp_agb, exp_aeb, exp_alb});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_agb  = 1'b0;
        exp_aeb  = 1'b0;
        exp_alb  = 1'b0;
        rst      = 1'b1;
        start    = 1'b1;
        A        = '0;
        B        = '0;

        // Reset wins over start
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", {29'd0, AGB, AEB, ALB}, 32'd0);

        // Idle without start stays idle
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_res", {29'd0, AGB, AEB, ALB}, 32'd0);

        // Directed cases: full-length equal, MSB-slice decision, slice-0 decision
        run_op("eq_a5", 8'hA5, 8'hA5, 1'b0, 1'b0);
        run_op("gt_c0", 8'hC0, 8'h40, 1'b0, 1'b0);
        run_op("lt_12", 8'h12, 8'h13, 1'b0, 1'b0);

        // start held high, operands changed mid-compare, back-to-back accept
        @(negedge clk);
        A     = 8'h00;
        B     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("hold_accept_busy", 32'(busy), 32'd1);
        A = 8'hFF;
        B = 8'h00;
        @(posedge clk);
        #1;
        check("hold_done", 32'(done), 32'd1);
        exp_agb = 1'b0;
        exp_aeb = 1'b0;
        exp_alb = 1'b1;
        check("hold_res", {29'd0, AGB, AEB, ALB}, 32'b001);
        @(posedge clk);
        #1;
        check("hold_idle_busy", 32'(busy), 32'd0);
        check("hold_idle_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("b2b_accept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_done", 32'(done), 32'd1);
        exp_agb = 1'b1;
        exp_aeb = 1'b0;
        exp_alb = 1'b0;
        check("b2b_res", {29'd0, AGB, AEB, ALB}, 32'b100);
        @(posedge clk);
        #1;
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Reset during the second compare cycle aborts without a done pulse
        @(negedge clk);
        A     = 8'h00;
        B     = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cmp2_busy", 32'(busy), 32'd1);
        check("abort_cmp2_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_agb = 1'b0;
        exp_aeb = 1'b0;
        exp_alb = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_res", {29'd0, AGB, AEB, ALB}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_stays_idle", 32'(busy), 32'd0);
        run_op("after_abort", 8'h3C, 8'h3D, 1'b0, 1'b0);

        // Corner operands
        run_op("c_zero", 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("c_ones", 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op("c_8080", 8'h80, 8'h7F, 1'b0, 1'b0);
        run_op("c_0100", 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("c_0001", 8'h00, 8'h01, 1'b0, 1'b1);
        run_op("c_4080", 8'h40, 8'h80, 1'b0, 1'b0);

        // Randomized operands with random start holding and operand disturbance
        for (int n = 0; n < 2000; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
